pipeline_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the EXE stage of the pipelined CPU. It adds MIPS-style mult/multu/div/divu plus HI/LO registers, which the current datapath lacks. It runs as a multi-cycle side unit and raises busy so the hazard logic stalls IF/ID and bubbles ID/EXE. HI/LO are architecturally visible through hi/lo outputs and direct writes (mthi/mtlo).

---
 rtl/pipeline_muldiv.sv | 150 +++++++++++++++
 tb/tb_pipeline_muldiv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_muldiv.sv
// Iterative radix-2 mult/multu/div/divu side unit with HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiply exits RUN once the multiplier is exhausted.
module pipeline_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   m_q;
   logic               is_div_q, neg_q, rneg_q, dbz_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               sgn, a_neg, b_neg, launch, early;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     msum, dtop, ddiff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_al, prod;
   logic [WIDTH-1:0]   q_fix, r_fix;

   always_comb begin
      sgn    = ~op[0];
      a_neg  = sgn & a[WIDTH-1];
      b_neg  = sgn & b[WIDTH-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      launch = (state_q == IDLE) & start & ~flush;
   end

   // Multiply: shift-add, low half holds the unconsumed multiplier bits.
   always_comb begin
      msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, acc_q[0] ? m_q : {WIDTH{1'b0}}};
      mul_nxt = {msum, acc_q[WIDTH-1:1]};
   end

   // Divide: restoring, remainder in the high half, quotient shifts in low.
   always_comb begin
      dtop    = acc_q[2*WIDTH-1:WIDTH-1];
      ddiff   = dtop - {1'b0, m_q};
      div_nxt = ddiff[WIDTH]
              ? {dtop[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
              : {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic [WIDTH-1:0] mask;
   always_comb begin
      mask   = ~({WIDTH{1'b1}} << cnt_q);
      early  = ~is_div_q & ((acc_q[WIDTH-1:0] & mask) == '0);
      acc_al = acc_q >> cnt_q;
   end
`else
   always_comb begin
      early  = 1'b0;
      acc_al = acc_q;
   end
`endif

   always_comb begin
      prod  = neg_q ? -acc_al : acc_al;
      q_fix = (neg_q & ~dbz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      r_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (launch) state_d = RUN;
         RUN: begin
            if (flush)                      state_d = IDLE;
            else if (early || cnt_q == 1)   state_d = FIX;
         end
         FIX:  state_d = flush ? IDLE : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         m_q      <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dbz_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  cnt_q    <= CNT_W'(WIDTH);
                  acc_q    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                  m_q      <= op[1] ? b_mag : a_mag;
                  is_div_q <= op[1];
                  neg_q    <= a_neg ^ b_neg;
                  rneg_q   <= a_neg;
                  dbz_q    <= op[1] & (b == '0);
               end else if (!start) begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            RUN: begin
               if (!flush && !early) begin
                  acc_q <= is_div_q ? div_nxt : mul_nxt;
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FIX: begin
               if (!flush) begin
                  hi_q <= is_div_q ? r_fix : prod[2*WIDTH-1:WIDTH];
                  lo_q <= is_div_q ? q_fix : prod[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q == RUN) | (state_q == FIX);
   assign done        = (state_q == DONE);
   assign div_by_zero = (state_q == DONE) & dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_pipeline_muldiv.sv
// Scoreboard bench for pipeline_muldiv: reference model results are queued
// at launch and compared when done pulses.
module tb_pipeline_muldiv;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic         hi_we = 1'b0;
   logic         lo_we = 1'b0;
   logic [1:0]   op    = '0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic [W-1:0] wdata = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   done_cnt = 0;

   pipeline_muldiv #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (done) done_cnt++;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [1:0] o,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y);
      exp_t e;
      logic signed [63:0] sp;
      logic [63:0] up;
      int sx, sy;
      e = '0;
      sx = x;
      sy = y;
      case (o)
         2'd0: begin
            sp = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
            e.hi = sp[63:32];
            e.lo = sp[31:0];
         end
         2'd1: begin
            up = {32'b0, x} * {32'b0, y};
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         default: begin
            if (y == 0) begin
               e.lo = '1;
               e.hi = x;
               e.dbz = 1'b1;
            end else if (o == 2'd2 && x == 32'h8000_0000 && y == '1) begin
               e.lo = x;
               e.hi = '0;
            end else if (o == 2'd2) begin
               e.lo = sx / sy;
               e.hi = sx % sy;
            end else begin
               e.lo = x / y;
               e.hi = x % y;
            end
         end
      endcase
      return e;
   endfunction

   // Called at a negedge; returns at the negedge of cycle 1.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      sb_q.push_back(model(o, x, y));
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic await_done(input string tag, input int k0,
                             input bit start_in_done);
      int   k;
      logic busy_bad;
      exp_t e;
      k = k0;
      busy_bad = 1'b0;
      while (!done && k < 200) begin
         if (!busy) busy_bad = 1'b1;
         @(negedge clock);
         k++;
      end
      check({tag, "_done_seen"}, done, 1'b1);
      if (done) begin
         if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
         end else begin
            e = sb_q.pop_front();
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
            check({tag, "_dbz"}, div_by_zero, e.dbz);
         end
`ifdef MULDIV_EARLY_OUT_EN
         check({tag, "_lat"}, (k <= W + 2), 1'b1);
`else
         check({tag, "_lat"}, k, W + 2);
`endif
         check({tag, "_busy_run"}, busy_bad, 1'b0);
         check({tag, "_busy_done"}, busy, 1'b0);
         if (start_in_done) begin
            op = 2'd0;
            a = 1;
            b = 1;
            start = 1'b1;
         end
         @(negedge clock);
         start = 1'b0;
         check({tag, "_pulse"}, {done, div_by_zero}, 2'b00);
         if (start_in_done) check({tag, "_start_in_done"}, busy, 1'b0);
      end
   endtask

   initial begin
      logic [W-1:0] h0, l0;
      int d0;

      repeat (3) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dbz", div_by_zero, 1'b0);
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
      reset = 1'b1;
      @(negedge clock);

      issue(2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
      await_done("mult_neg", 1, 1'b0);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      await_done("multu_max", 1, 1'b1);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2);
      await_done("div_neg", 1, 1'b0);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      await_done("div_ovf", 1, 1'b0);
      issue(2'd3, 32'd100, 32'd0);
      await_done("divu_zero", 1, 1'b0);
      issue(2'd2, 32'hFFFF_FF9C, 32'd0);
      await_done("div_zero_neg", 1, 1'b0);

      // second start while busy must not disturb the running op
      issue(2'd1, 32'd6, 32'd7);
      repeat (3) @(negedge clock);
      op = 2'd3;
      a = 32'd1;
      b = 32'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      d0 = done_cnt;
      await_done("start_busy", 5, 1'b0);
      repeat (40) @(negedge clock);
      check("start_busy_one_done", done_cnt - d0, 1);

      for (int i = 0; i < 6; i++) begin
         issue(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0
               ? 32'($urandom_range(1, 255)) : $urandom);
         await_done($sformatf("rand%0d", i), 1, 1'b0);
      end

      // hi/lo writes with start in the same cycle are dropped
      h0 = hi;
      l0 = lo;
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      issue(2'd1, 32'd2, 32'd3);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("we_start_hi", hi, h0);
      check("we_start_lo", lo, l0);
      await_done("we_start", 1, 1'b0);

      // mthi then a flushed mult
      wdata = 32'h1234_5678;
      hi_we = 1'b1;
      @(negedge clock);
      hi_we = 1'b0;
      check("mthi", hi, 32'h1234_5678);
      l0 = lo;
      d0 = done_cnt;
      op = 2'd0;
      a = 32'd5;
      b = 32'd7;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      op = 2'd0;
      a = 32'd9;
      b = 32'd9;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      repeat (40) @(negedge clock);
      check("flush_no_done", done_cnt - d0, 0);
      check("flush_hi", hi, 32'h1234_5678);
      check("flush_lo", lo, l0);
      check("flush_idle", busy, 1'b0);

      // async reset mid divu
      op = 2'd3;
      a = 32'd100;
      b = 32'd7;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (19) @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_hi", hi, '0);
      check("mid_rst_lo", lo, '0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      issue(2'd3, 32'd100, 32'd7);
      await_done("divu_after_rst", 1, 1'b0);
      issue(2'd1, 32'd3, 32'd1);
      await_done("multu_small", 1, 1'b0);
      issue(2'd0, 32'h1234_5678, 32'd0);
      await_done("mult_zero", 1, 1'b0);

      check("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
